// File: rtl/bf_exec_controller.sv
// Brainfuck instruction sequencer: fetches program bytes, drives pointer/RAM/IO strobes, scans brackets.
// Latency: 2 cycles for '>'/'<'/comments, 3-4 for RAM ops; the IO waits hold until the handshake completes.
module bf_exec_controller #(
    parameter int PAW     = 10,
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [PAW-1:0]     p_addr,
    input  logic [7:0]         p_data,
    output logic               ptr_inc,
    output logic               ptr_dec,
    output logic               m_rd,
    input  logic [7:0]         m_rdata,
    output logic               m_wr,
    output logic [7:0]         m_wdata,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               busy,
    output logic               halted,
    output logic               error
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WR,
        S_OUT_WAIT, S_IN_WAIT, S_SCAN_F, S_SCAN_B, S_HALT
    } state_t;

    localparam logic [7:0] C_RIGHT = 8'h3E;
    localparam logic [7:0] C_LEFT  = 8'h3C;
    localparam logic [7:0] C_INC   = 8'h2B;
    localparam logic [7:0] C_DEC   = 8'h2D;
    localparam logic [7:0] C_OUT   = 8'h2E;
    localparam logic [7:0] C_IN    = 8'h2C;
    localparam logic [7:0] C_LB    = 8'h5B;
    localparam logic [7:0] C_RB    = 8'h5D;

    localparam logic [PAW-1:0]     PC_ONE = 1;
    localparam logic [PAW-1:0]     PC_MAX = '1;
    localparam logic [DEPTH_W-1:0] D_ONE  = 1;
    localparam logic [DEPTH_W-1:0] D_MAX  = '1;

    state_t             state, state_nx;
    logic [PAW-1:0]     pc, pc_nx;
    logic [DEPTH_W-1:0] depth, depth_nx;
    logic [7:0]         op, op_nx;
    logic               scan_ph, scan_ph_nx;
    logic [7:0]         wdata_q, wdata_nx;
    logic [7:0]         out_q, out_nx;
    logic               err_q, err_nx;
    logic               step, fail;
    logic               pc_last, pc_zero;

    assign pc_last = (pc == PC_MAX);
    assign pc_zero = (pc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            depth   <= '0;
            op      <= '0;
            scan_ph <= 1'b0;
            wdata_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            depth   <= depth_nx;
            op      <= op_nx;
            scan_ph <= scan_ph_nx;
            wdata_q <= wdata_nx;
            out_q   <= out_nx;
            err_q   <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        depth_nx   = depth;
        op_nx      = op;
        scan_ph_nx = scan_ph;
        wdata_nx   = wdata_q;
        out_nx     = out_q;
        err_nx     = err_q;
        ptr_inc    = 1'b0;
        ptr_dec    = 1'b0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        step       = 1'b0;
        fail       = 1'b0;

        case (state)
            S_IDLE: begin
                pc_nx    = '0;
                depth_nx = '0;
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                op_nx = p_data;
                case (p_data)
                    C_RIGHT: begin ptr_inc = 1'b1; step = 1'b1; end
                    C_LEFT:  begin ptr_dec = 1'b1; step = 1'b1; end
                    C_INC, C_DEC, C_OUT, C_LB, C_RB: begin
                        m_rd     = 1'b1;
                        state_nx = S_MEM_RD;
                    end
                    C_IN:    state_nx = S_IN_WAIT;
                    8'h00:   state_nx = S_HALT;
                    default: step = 1'b1;
                endcase
            end
            S_MEM_RD: begin
                case (op)
                    C_INC: begin wdata_nx = m_rdata + 8'd1; state_nx = S_MEM_WR; end
                    C_DEC: begin wdata_nx = m_rdata - 8'd1; state_nx = S_MEM_WR; end
                    C_OUT: begin out_nx = m_rdata; state_nx = S_OUT_WAIT; end
                    C_LB: begin
                        if (m_rdata != 8'd0) step = 1'b1;
                        else if (pc_last) fail = 1'b1;
                        else begin
                            pc_nx      = pc + PC_ONE;
                            depth_nx   = D_ONE;
                            scan_ph_nx = 1'b0;
                            state_nx   = S_SCAN_F;
                        end
                    end
                    C_RB: begin
                        if (m_rdata == 8'd0) step = 1'b1;
                        else if (pc_zero) fail = 1'b1;
                        else begin
                            pc_nx      = pc - PC_ONE;
                            depth_nx   = D_ONE;
                            scan_ph_nx = 1'b0;
                            state_nx   = S_SCAN_B;
                        end
                    end
                    default: step = 1'b1;
                endcase
            end
            S_MEM_WR: begin
                m_wr = 1'b1;
                step = 1'b1;
            end
            S_IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_wr     = 1'b1;
                    wdata_nx = in_data;
                    step     = 1'b1;
                end
            end
            S_OUT_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) step = 1'b1;
            end
            S_SCAN_F: begin
                // Phase 0 presents pc to the ROM; phase 1 examines the returned byte.
                scan_ph_nx = ~scan_ph;
                if (scan_ph) begin
                    if (p_data == C_RB && depth == D_ONE) begin
                        depth_nx = '0;
                        step     = 1'b1;
                    end else if (p_data == C_LB && depth == D_MAX) begin
                        fail = 1'b1;
                    end else begin
                        if (p_data == C_LB) depth_nx = depth + D_ONE;
                        if (p_data == C_RB) depth_nx = depth - D_ONE;
                        if (pc_last) fail = 1'b1;
                        else         pc_nx = pc + PC_ONE;
                    end
                end
            end
            S_SCAN_B: begin
                scan_ph_nx = ~scan_ph;
                if (scan_ph) begin
                    if (p_data == C_LB && depth == D_ONE) begin
                        depth_nx = '0;
                        step     = 1'b1;
                    end else if (p_data == C_RB && depth == D_MAX) begin
                        fail = 1'b1;
                    end else begin
                        if (p_data == C_RB) depth_nx = depth + D_ONE;
                        if (p_data == C_LB) depth_nx = depth - D_ONE;
                        if (pc_zero) fail = 1'b1;
                        else         pc_nx = pc - PC_ONE;
                    end
                end
            end
            S_HALT: begin
                if (!run) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Running off the end of the program is a normal stop; scan overruns are errors.
        if (step) begin
            if (pc_last) state_nx = S_HALT;
            else begin
                pc_nx    = pc + PC_ONE;
                state_nx = S_FETCH;
            end
        end
        if (fail) begin
            err_nx   = 1'b1;
            state_nx = S_HALT;
        end
    end

    assign p_addr   = pc;
    assign m_wdata  = (state == S_IN_WAIT) ? in_data : wdata_q;
    assign out_data = out_q;
    assign busy     = (state != S_IDLE) && (state != S_HALT);
    assign halted   = (state == S_HALT);
    assign error    = err_q;

endmodule

// File: tb/tb_bf_exec_controller.sv
// Directed bench for bf_exec_controller with behavioural program ROM, data RAM and pointer.
module tb_bf_exec_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [9:0] p_addr;
    logic [7:0] p_data = 8'd0;
    logic       ptr_inc, ptr_dec, m_rd, m_wr;
    logic [7:0] m_rdata = 8'd0;
    logic [7:0] m_wdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       busy, halted, error;

    bf_exec_controller #(.PAW(10), .DEPTH_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .p_addr(p_addr), .p_data(p_data),
        .ptr_inc(ptr_inc), .ptr_dec(ptr_dec),
        .m_rd(m_rd), .m_rdata(m_rdata), .m_wr(m_wr), .m_wdata(m_wdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:1023];
    logic [7:0] ram [0:255];
    logic [7:0] ptr = 8'd0;
    logic       ptr_clr = 1'b0, ram_clr = 1'b0, ram_set = 1'b0;
    logic [7:0] ram_set_val = 8'd0;

    always @(posedge clk) p_data <= rom[p_addr];

    always @(posedge clk) begin
        if (ptr_clr)      ptr <= 8'd0;
        else if (ptr_inc) ptr <= ptr + 8'd1;
        else if (ptr_dec) ptr <= ptr - 8'd1;
    end

    always @(posedge clk) begin
        if (m_rd) m_rdata <= ram[ptr];
        if (ram_clr) for (int i = 0; i < 256; i++) ram[i] <= 8'd0;
        else if (m_wr) ram[ptr] <= m_wdata;
        if (ram_set) ram[0] <= ram_set_val;
    end

    int cyc = 0, n_inc = 0, n_dec = 0, n_rd = 0, n_wr = 0, n_out = 0, n_ptr = 0, viol = 0;
    logic [7:0] last_wdata = 8'd0, last_out = 8'd0;
    int ptr_log [0:15];
    logic ptr_kind [0:15];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ptr_inc || ptr_dec) begin
            if (n_ptr < 16) begin
                ptr_log[n_ptr]  <= cyc;
                ptr_kind[n_ptr] <= ptr_inc;
            end
            n_ptr <= n_ptr + 1;
        end
        if (ptr_inc) n_inc <= n_inc + 1;
        if (ptr_dec) n_dec <= n_dec + 1;
        if ((ptr_inc && ptr_dec) || (m_rd && m_wr)) viol <= viol + 1;
        if (m_rd) n_rd <= n_rd + 1;
        if (m_wr) begin n_wr <= n_wr + 1; last_wdata <= m_wdata; end
        if (out_valid && out_ready) begin n_out <= n_out + 1; last_out <= out_data; end
    end

    int total = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input string s, input bit clr, input bit set, input logic [7:0] val);
        bit ok;
        @(posedge clk); #1;
        run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            ok = !busy && !halted;
        end
        check("reach_idle", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 1024; i++) rom[i] = 8'd0;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
        ptr_clr = 1'b1; ram_clr = clr; ram_set = set; ram_set_val = val;
        @(posedge clk); #1;
        ptr_clr = 1'b0; ram_clr = 1'b0; ram_set = 1'b0;
        run = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = halted;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    int b_inc, b_dec, b_rd, b_wr, b_out, b_ptr, held;
    bit ok;

    task automatic snap();
        b_inc = n_inc; b_dec = n_dec; b_rd = n_rd; b_wr = n_wr; b_out = n_out; b_ptr = n_ptr;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'd0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_paddr", {22'd0, p_addr}, 32'd0);
        check("rst_strobes", {28'd0, ptr_inc, ptr_dec, m_rd, m_wr}, 32'd0);
        check("rst_io", {30'd0, out_valid, in_ready}, 32'd0);
        check("rst_wdata", {24'd0, m_wdata}, 32'd0);
        check("rst_outdata", {24'd0, out_data}, 32'd0);
        #20 rst_n = 1'b1;

        snap(); start("+++.", 1, 0, 8'd0); wait_halt("t1_halt");
        check("t1_nout", n_out - b_out, 1);
        check("t1_outdata", {24'd0, last_out}, 32'h03);
        check("t1_nwr", n_wr - b_wr, 3);
        check("t1_error", {31'd0, error}, 32'd0);

        snap(); start("-", 1, 0, 8'd0); wait_halt("t2_halt");
        check("t2_wdata", {24'd0, last_wdata}, 32'hFF);
        check("t2_nwr", n_wr - b_wr, 1);
        check("t2_cell", {24'd0, ram[0]}, 32'hFF);

        snap(); start("+", 0, 0, 8'd0); wait_halt("t3_halt");
        check("t3_wdata", {24'd0, last_wdata}, 32'h00);
        check("t3_cell", {24'd0, ram[0]}, 32'h00);

        snap(); start("><<", 1, 0, 8'd0); wait_halt("t4_halt");
        check("t4_ninc", n_inc - b_inc, 1);
        check("t4_ndec", n_dec - b_dec, 2);
        check("t4_ram", (n_rd - b_rd) + (n_wr - b_wr), 0);
        check("t4_order", {29'd0, ptr_kind[b_ptr], ptr_kind[b_ptr+1], ptr_kind[b_ptr+2]}, 32'b100);
        check("t4_gap1", ptr_log[b_ptr+1] - ptr_log[b_ptr], 2);
        check("t4_gap2", ptr_log[b_ptr+2] - ptr_log[b_ptr+1], 2);
        check("t4_ptr", {24'd0, ptr}, 32'hFF);

        snap(); start("[[+]x].", 1, 0, 8'd0); wait_halt("t5_halt");
        check("t5_nout", n_out - b_out, 1);
        check("t5_outdata", {24'd0, last_out}, 32'h00);
        check("t5_nwr", n_wr - b_wr, 0);
        check("t5_error", {31'd0, error}, 32'd0);

        snap(); start("++[-]", 1, 0, 8'd0); wait_halt("t6_halt");
        check("t6_cell", {24'd0, ram[0]}, 32'h00);
        check("t6_nwr", n_wr - b_wr, 4);
        check("t6_error", {31'd0, error}, 32'd0);

        out_ready = 1'b0;
        snap(); start(",.", 1, 0, 8'd0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); #1; ok = in_ready; end
        check("t7_inready", {31'd0, ok}, 32'd1);
        held = 0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (in_ready) held++; end
        check("t7_in_held", held, 5);
        in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); #1; ok = out_valid; end
        check("t7_outvalid", {31'd0, ok}, 32'd1);
        held = 0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (out_valid) held++; end
        check("t7_out_held", held, 3);
        check("t7_outdata_held", {24'd0, out_data}, 32'h5A);
        out_ready = 1'b1;
        wait_halt("t7_halt");
        check("t7_nout", n_out - b_out, 1);
        check("t7_echo", {24'd0, last_out}, 32'h5A);
        check("t7_nwr", n_wr - b_wr, 1);

        snap(); start("]", 1, 1, 8'h05); wait_halt("t8_halt");
        check("t8_error", {31'd0, error}, 32'd1);
        check("t8_halted", {31'd0, halted}, 32'd1);

        out_ready = 1'b0;
        start(".", 1, 0, 8'd0);
        check("t9_sticky", {31'd0, error}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); #1; ok = out_valid; end
        check("t9_outvalid", {31'd0, ok}, 32'd1);
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t9_busy", {31'd0, busy}, 32'd0);
        check("t9_halted", {31'd0, halted}, 32'd0);
        check("t9_outvalid0", {31'd0, out_valid}, 32'd0);
        check("t9_error0", {31'd0, error}, 32'd0);
        check("t9_paddr", {22'd0, p_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t9_idle", {30'd0, busy, halted}, 32'd0);
        check("excl_strobes", viol, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
